// File: rtl/bmem_line_adapter.sv
// Arbitrates icache/dcache line requests onto 4-beat bmem bursts; reads reassemble by raddr, resp 1 cycle after last beat.
// Backpressure: bmem_ready stalls issue/beats with outputs held; BMEM_ADAPTER_PERF_EN adds internal *_hk counters.
module bmem_line_adapter #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 64,
    parameter int BURST_LEN  = 4,
    parameter int LINE_WIDTH = BEAT_WIDTH * BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_resp_valid,
    output logic [LINE_WIDTH-1:0] ic_resp_data,
    input  logic                  dc_req_valid,
    input  logic                  dc_req_write,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [LINE_WIDTH-1:0] dc_req_wdata,
    output logic                  dc_req_ready,
    output logic                  dc_resp_valid,
    output logic [LINE_WIDTH-1:0] dc_resp_data,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid,
    output logic                  err
);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int LA_W  = ADDR_WIDTH - OFF_W;
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_BURST} state_t;

    state_t                 state;
    logic                   grant_ic;
    logic                   last_dc;
    logic [CNT_W-1:0]       wr_beat;
    logic                   ic_pend, dc_pend;
    logic [LA_W-1:0]        ic_line, dc_line;
    logic [CNT_W-1:0]       ic_cnt, dc_cnt;
    logic [LINE_WIDTH-1:0]  ic_buf, dc_buf;

    logic ic_elig, dc_elig, pick_ic, ic_hit, dc_hit, ic_done, dc_done;
    logic [CNT_W-1:0] wr_next;
    logic unused_addr_bits;

    // A client whose ready pulse is still visible is treated as outstanding: it
    // has not yet had a chance to drop its valid.
    assign ic_elig = ic_req_valid && !ic_pend && !ic_req_ready;
    assign dc_elig = dc_req_valid && !dc_pend && !dc_req_ready;
    assign pick_ic = ic_elig && (!dc_elig || last_dc);
    assign ic_hit  = bmem_rvalid && ic_pend && (bmem_raddr[ADDR_WIDTH-1:OFF_W] == ic_line);
    assign dc_hit  = bmem_rvalid && dc_pend && (bmem_raddr[ADDR_WIDTH-1:OFF_W] == dc_line);
    assign ic_done = ic_hit && (ic_cnt == LAST);
    assign dc_done = dc_hit && (dc_cnt == LAST);
    assign wr_next = wr_beat + 1'b1;
    assign unused_addr_bits = ^{ic_req_addr[OFF_W-1:0], dc_req_addr[OFF_W-1:0], bmem_raddr[OFF_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant_ic      <= 1'b0;
            last_dc       <= 1'b1;
            wr_beat       <= '0;
            ic_pend       <= 1'b0;
            dc_pend       <= 1'b0;
            ic_line       <= '0;
            dc_line       <= '0;
            ic_cnt        <= '0;
            dc_cnt        <= '0;
            ic_buf        <= '0;
            dc_buf        <= '0;
            ic_req_ready  <= 1'b0;
            ic_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            dc_req_ready  <= 1'b0;
            dc_resp_valid <= 1'b0;
            dc_resp_data  <= '0;
            bmem_addr     <= '0;
            bmem_read     <= 1'b0;
            bmem_write    <= 1'b0;
            bmem_wdata    <= '0;
            err           <= 1'b0;
        end else begin
            ic_req_ready  <= 1'b0;
            dc_req_ready  <= 1'b0;
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ic_elig || dc_elig) begin
                        // The round-robin pointer only moves on a real conflict.
                        if (ic_elig && dc_elig)
                            last_dc <= !pick_ic;
                        grant_ic  <= pick_ic;
                        bmem_addr <= {(pick_ic ? ic_req_addr[ADDR_WIDTH-1:OFF_W]
                                               : dc_req_addr[ADDR_WIDTH-1:OFF_W]), {OFF_W{1'b0}}};
                        if (!pick_ic && dc_req_write) begin
                            state      <= WR_BURST;
                            bmem_write <= 1'b1;
                            wr_beat    <= '0;
                            bmem_wdata <= dc_req_wdata[BEAT_WIDTH-1:0];
                        end else begin
                            state     <= RD_ISSUE;
                            bmem_read <= 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        state     <= IDLE;
                        if (grant_ic) begin
                            ic_req_ready <= 1'b1;
                            ic_pend      <= 1'b1;
                            ic_line      <= bmem_addr[ADDR_WIDTH-1:OFF_W];
                        end else begin
                            dc_req_ready <= 1'b1;
                            dc_pend      <= 1'b1;
                            dc_line      <= bmem_addr[ADDR_WIDTH-1:OFF_W];
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        if (wr_beat == LAST) begin
                            bmem_write    <= 1'b0;
                            dc_req_ready  <= 1'b1;
                            dc_resp_valid <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            wr_beat    <= wr_next;
                            bmem_wdata <= dc_req_wdata[int'(wr_next)*BEAT_WIDTH +: BEAT_WIDTH];
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (ic_hit) begin
                ic_buf[int'(ic_cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
                ic_cnt <= ic_cnt + 1'b1;
                if (ic_done) begin
                    ic_cnt        <= '0;
                    ic_pend       <= 1'b0;
                    ic_resp_valid <= 1'b1;
                    ic_resp_data  <= {bmem_rdata, ic_buf[LINE_WIDTH-BEAT_WIDTH-1:0]};
                end
            end
            if (dc_hit) begin
                dc_buf[int'(dc_cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= bmem_rdata;
                dc_cnt <= dc_cnt + 1'b1;
                if (dc_done) begin
                    dc_cnt        <= '0;
                    dc_pend       <= 1'b0;
                    dc_resp_valid <= 1'b1;
                    dc_resp_data  <= {bmem_rdata, dc_buf[LINE_WIDTH-BEAT_WIDTH-1:0]};
                end
            end
            if (bmem_rvalid && !ic_hit && !dc_hit)
                err <= 1'b1;
        end
    end

`ifdef BMEM_ADAPTER_PERF_EN
    logic [31:0] rd_bursts_hk, wr_bursts_hk, arb_conflict_hk, ready_stall_hk, rd_latency_total_hk;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Latency accrues one per pending cycle plus one on the completing beat,
    // which equals issue-to-resp_valid cycles for each read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bursts_hk        <= '0;
            wr_bursts_hk        <= '0;
            arb_conflict_hk     <= '0;
            ready_stall_hk      <= '0;
            rd_latency_total_hk <= '0;
        end else begin
            rd_bursts_hk    <= sat_add(rd_bursts_hk, 32'(state == RD_ISSUE && bmem_ready));
            wr_bursts_hk    <= sat_add(wr_bursts_hk, 32'(state == WR_BURST && bmem_ready && wr_beat == LAST));
            arb_conflict_hk <= sat_add(arb_conflict_hk, 32'(state == IDLE && ic_elig && dc_elig));
            ready_stall_hk  <= sat_add(ready_stall_hk, 32'((bmem_read || bmem_write) && !bmem_ready));
            rd_latency_total_hk <= sat_add(rd_latency_total_hk,
                32'(ic_pend) + 32'(dc_pend) + 32'(ic_done) + 32'(dc_done));
        end
    end
`endif

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed bench with random data against a line-level memory model for bmem_line_adapter.
module tb_bmem_line_adapter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ic_req_valid = 1'b0;
    logic [31:0]  ic_req_addr = '0;
    logic         ic_req_ready, ic_resp_valid;
    logic [255:0] ic_resp_data;
    logic         dc_req_valid = 1'b0, dc_req_write = 1'b0;
    logic [31:0]  dc_req_addr = '0;
    logic [255:0] dc_req_wdata = '0;
    logic         dc_req_ready, dc_resp_valid;
    logic [255:0] dc_resp_data;
    logic [31:0]  bmem_addr;
    logic         bmem_read, bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready = 1'b0;
    logic [31:0]  bmem_raddr = '0;
    logic [63:0]  bmem_rdata = '0;
    logic         bmem_rvalid = 1'b0;
    logic         err;

    int total = 0;
    int bad = 0;
    logic [255:0] ic_last, dc_last;

    bmem_line_adapter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ic_req_valid = 1'b0; dc_req_valid = 1'b0; dc_req_write = 1'b0;
        bmem_ready = 1'b0; bmem_rvalid = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        ic_last = '0;
        dc_last = '0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Waits for a read burst, stalls it one cycle, then accepts it and checks which client is told.
    task automatic accept_read(input string tag, input logic [31:0] addr, input bit is_ic);
        int n;
        logic [31:0] aligned;
        aligned = {addr[31:5], 5'b0};
        n = 0;
        while (bmem_read !== 1'b1 && n < 16) begin cyc(); n++; end
        chk({tag, "_rd"}, bmem_read, 1);
        chk({tag, "_addr"}, bmem_addr, aligned);
        bmem_ready = 1'b0;
        cyc();
        chk({tag, "_hold"}, {bmem_read, bmem_write, ic_req_ready, dc_req_ready, bmem_addr}, {4'b1000, aligned});
        bmem_ready = 1'b1;
        cyc();
        bmem_ready = 1'b0;
        chk({tag, "_rdy"}, {ic_req_ready, dc_req_ready, bmem_read}, is_ic ? 3'b100 : 3'b010);
        if (is_ic) ic_req_valid = 1'b0; else dc_req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] raddr, input logic [63:0] d);
        bmem_rvalid = 1'b1;
        bmem_raddr = raddr;
        bmem_rdata = d;
        cyc();
        bmem_rvalid = 1'b0;
        bmem_raddr = '0;
        bmem_rdata = '0;
    endtask

    initial begin
        logic [63:0]  ib[4], db[4];
        logic [255:0] wline, line;
        int           pat[6];
        int           k, n;

        do_reset();
        chk("reset_outs", {ic_req_ready, ic_resp_valid, dc_req_ready, dc_resp_valid, bmem_read, bmem_write, err}, 0);
        chk("reset_addr", bmem_addr, 0);
        chk("reset_data", {ic_resp_data, dc_resp_data}, 0);

        // Icache line read with unaligned low bits.
        ic_req_addr = 32'h1000 | 32'($urandom_range(0, 31));
        ic_req_valid = 1'b1;
        accept_read("ic1", 32'h1000, 1'b1);
        cyc();
        for (int i = 0; i < 4; i++) ib[i] = rnd64();
        for (int i = 0; i < 4; i++) begin
            chk("ic1_noresp_early", ic_resp_valid, 0);
            send_beat(32'h1000 + 32'(i * 8), ib[i]);
        end
        ic_last = {ib[3], ib[2], ib[1], ib[0]};
        chk("ic1_resp", {ic_resp_valid, dc_resp_valid}, 2'b10);
        chk("ic1_data", ic_resp_data, ic_last);
        chk("ic1_err", err, 0);
        cyc();
        chk("ic1_pulse", ic_resp_valid, 0);
        chk("ic1_stable", ic_resp_data, ic_last);

        // Dcache write with two stall cycles on beat 1.
        wline = {rnd64(), rnd64(), rnd64(), rnd64()};
        dc_req_addr = 32'h2040; dc_req_write = 1'b1; dc_req_wdata = wline; dc_req_valid = 1'b1;
        n = 0;
        while (bmem_write !== 1'b1 && n < 16) begin cyc(); n++; end
        pat = '{1, 0, 0, 1, 1, 1};
        k = 0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("wr_cyc%0d_ctl", i), {bmem_write, bmem_read, dc_req_ready, dc_resp_valid}, 4'b1000);
            chk($sformatf("wr_cyc%0d_addr", i), bmem_addr, 32'h2040);
            chk($sformatf("wr_cyc%0d_beat", i), bmem_wdata, wline[k*64 +: 64]);
            bmem_ready = pat[i][0];
            cyc();
            if (pat[i] != 0) k++;
        end
        bmem_ready = 1'b0;
        chk("wr_ack", {dc_req_ready, dc_resp_valid, bmem_write}, 3'b110);
        chk("wr_resp_data", dc_resp_data, dc_last);
        dc_req_valid = 1'b0; dc_req_write = 1'b0;
        cyc();
        chk("wr_ack_pulse", {dc_req_ready, dc_resp_valid, bmem_write, bmem_read}, 0);

        // Simultaneous requests after reset: icache first, interleaved returns.
        do_reset();
        ic_req_addr = 32'h3000; ic_req_valid = 1'b1;
        dc_req_addr = 32'h4000; dc_req_write = 1'b0; dc_req_valid = 1'b1;
        accept_read("arb1_ic", 32'h3000, 1'b1);
        accept_read("arb1_dc", 32'h4000, 1'b0);
        for (int i = 0; i < 4; i++) begin ib[i] = rnd64(); db[i] = rnd64(); end
        for (int i = 0; i < 4; i++) begin
            send_beat(32'h4000 + 32'(8 * ((i + 1) % 4)), db[i]);
            if (i == 3) begin
                dc_last = {db[3], db[2], db[1], db[0]};
                chk("il_dc_resp", {ic_resp_valid, dc_resp_valid}, 2'b01);
                chk("il_dc_data", dc_resp_data, dc_last);
            end
            send_beat(32'h3000 + 32'(8 * i), ib[i]);
        end
        ic_last = {ib[3], ib[2], ib[1], ib[0]};
        chk("il_ic_resp", {ic_resp_valid, dc_resp_valid}, 2'b10);
        chk("il_ic_data", ic_resp_data, ic_last);
        chk("il_dc_stable", dc_resp_data, dc_last);

        // Second conflict goes to the dcache; both read the same line.
        ic_req_addr = 32'h5008; ic_req_valid = 1'b1;
        dc_req_addr = 32'h5010; dc_req_valid = 1'b1;
        accept_read("arb2_dc", 32'h5000, 1'b0);
        accept_read("arb2_ic", 32'h5000, 1'b1);
        for (int i = 0; i < 4; i++) ib[i] = rnd64();
        for (int i = 0; i < 4; i++) send_beat(32'h5000 + 32'(8 * i), ib[i]);
        line = {ib[3], ib[2], ib[1], ib[0]};
        chk("shared_resp", {ic_resp_valid, dc_resp_valid}, 2'b11);
        chk("shared_ic_data", ic_resp_data, line);
        chk("shared_dc_data", dc_resp_data, line);
        chk("shared_err", err, 0);

        // Unmatched return beat sets sticky err.
        send_beat(32'h9000, rnd64());
        chk("err_set", err, 1);
        repeat (3) cyc();
        chk("err_sticky", err, 1);

        // Reset during a write burst.
        dc_req_addr = 32'h6000; dc_req_write = 1'b1; dc_req_wdata = {rnd64(), rnd64(), rnd64(), rnd64()};
        dc_req_valid = 1'b1;
        n = 0;
        while (bmem_write !== 1'b1 && n < 16) begin cyc(); n++; end
        chk("rstw_started", bmem_write, 1);
        bmem_ready = 1'b1;
        cyc();
        bmem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstw_drop", {bmem_write, bmem_read, err, dc_req_ready, dc_resp_valid}, 0);
        dc_req_valid = 1'b0; dc_req_write = 1'b0;
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("rstw_quiet", {bmem_write, bmem_read, err, dc_req_ready, dc_resp_valid}, 0);
        chk("rstw_data", dc_resp_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
